sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count-based status flags, sticky error flags and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       wr,
    input  logic                       rd,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;

    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= CW'(AF_LEVEL));
        almost_empty = (count_q <= CW'(AE_LEVEL));
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // A write into a full FIFO is still taken when a read frees a slot on the same edge.
    always_comb begin
        rd_acc      = rd && !empty;
        wr_acc      = wr && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr && full && !rd) overflow_d  = 1'b1;
            if (rd && empty)       underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem_q[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        always_comb data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (clr)         dout_d = '0;
            else if (rd_acc) dout_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else        dout_q <= dout_d;
        end

        always_comb data_out = dout_q;
    end

endmodule
